// File: rtl/stepper_pkg.sv
// Shared types and constants for the two-axis STEP/DIR pulse generator.
// Default phase timings are overridable through stepper_driver parameters.
package stepper_pkg;

    localparam int unsigned STEP_CNT_W          = 64;
    localparam int unsigned TIMER_W             = 32;
    localparam int unsigned DEF_PULSE_HIGH_CYC  = 50;
    localparam int unsigned DEF_STEP_PERIOD_CYC = 500;
    localparam int unsigned DEF_DIR_SETUP_CYC   = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIR_SETUP,
        ST_STEP_HIGH,
        ST_STEP_LOW
    } state_e;

endpackage

// File: rtl/stepper_driver_step_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero, so loading
// N-1 on phase entry makes tc_o fire in the N-th cycle of that phase.
module step_timer #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/stepper_driver.sv
// Two-axis STEP/DIR generator with Bresenham interpolation of the minor axis.
// Optional STEPPER_POS_TRACK_EN adds signed position counters pos1/pos2.
module stepper_driver
    import stepper_pkg::*;
#(
    parameter int unsigned PULSE_HIGH_CYC  = DEF_PULSE_HIGH_CYC,
    parameter int unsigned STEP_PERIOD_CYC = DEF_STEP_PERIOD_CYC,
    parameter int unsigned DIR_SETUP_CYC   = DEF_DIR_SETUP_CYC
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [STEP_CNT_W-1:0] m1_steps,
    input  logic [STEP_CNT_W-1:0] m2_steps,
    input  logic                  dir1,
    input  logic                  dir2,
    input  logic                  abort,
    output logic                  step1,
    output logic                  step2,
    output logic                  dir1_out,
    output logic                  dir2_out,
    output logic                  stepper_ready,
    output logic                  move_done
`ifdef STEPPER_POS_TRACK_EN
    ,
    output logic signed [STEP_CNT_W-1:0] pos1,
    output logic signed [STEP_CNT_W-1:0] pos2
`endif
);

    localparam logic [TIMER_W-1:0] DIR_LOAD  = TIMER_W'(DIR_SETUP_CYC - 1);
    localparam logic [TIMER_W-1:0] HIGH_LOAD = TIMER_W'(PULSE_HIGH_CYC - 1);
    localparam logic [TIMER_W-1:0] LOW_LOAD  = TIMER_W'(STEP_PERIOD_CYC - PULSE_HIGH_CYC - 1);

    state_e                  state_q, state_d;
    logic [STEP_CNT_W-1:0]   major_q, major_d;
    logic [STEP_CNT_W-1:0]   minor_q, minor_d;
    logic [STEP_CNT_W-1:0]   rem_q, rem_d;
    logic [STEP_CNT_W:0]     err_q, err_d;
    logic [STEP_CNT_W:0]     err_sum;
    logic                    maj1_q, maj1_d;
    logic                    abort_pend_q, abort_pend_d;
    logic                    step1_q, step1_d, step2_q, step2_d;
    logic                    dir1_q, dir1_d, dir2_q, dir2_d;
    logic                    ready_q, ready_d, done_q, done_d;
    logic                    minor_step, enter_high, zero_acc;
    logic                    tmr_load, tmr_tc;
    logic [TIMER_W-1:0]      tmr_val;
`ifdef STEPPER_POS_TRACK_EN
    logic signed [STEP_CNT_W-1:0] pos1_q, pos1_d, pos2_q, pos2_d;
`endif

    step_timer #(.W(TIMER_W)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    // err stays below major, so the sum never needs more than one extra bit.
    assign err_sum    = err_q + {1'b0, minor_q};
    assign minor_step = (err_sum >= {1'b0, major_q});

    always_comb begin
        state_d      = state_q;
        major_d      = major_q;
        minor_d      = minor_q;
        rem_d        = rem_q;
        err_d        = err_q;
        maj1_d       = maj1_q;
        abort_pend_d = abort_pend_q;
        step1_d      = step1_q;
        step2_d      = step2_q;
        dir1_d       = dir1_q;
        dir2_d       = dir2_q;
        done_d       = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        enter_high   = 1'b0;
        zero_acc     = 1'b0;
`ifdef STEPPER_POS_TRACK_EN
        pos1_d       = pos1_q;
        pos2_d       = pos2_q;
`endif
        case (state_q)
            ST_IDLE: begin
                abort_pend_d = 1'b0;
                if (start && ready_q && !abort) begin
                    dir1_d = dir1;
                    dir2_d = dir2;
                    err_d  = '0;
                    if (m1_steps >= m2_steps) begin
                        major_d = m1_steps;
                        minor_d = m2_steps;
                        maj1_d  = 1'b1;
                        rem_d   = m1_steps;
                    end else begin
                        major_d = m2_steps;
                        minor_d = m1_steps;
                        maj1_d  = 1'b0;
                        rem_d   = m2_steps;
                    end
                    if (m1_steps == '0 && m2_steps == '0) begin
                        zero_acc = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        state_d  = ST_DIR_SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = DIR_LOAD;
                    end
                end
            end
            ST_DIR_SETUP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (tmr_tc) begin
                    enter_high = 1'b1;
                end
            end
            ST_STEP_HIGH: begin
                // An abort here is remembered so the pulse keeps its full width.
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (tmr_tc) begin
                    state_d  = ST_STEP_LOW;
                    tmr_load = 1'b1;
                    tmr_val  = LOW_LOAD;
                    step1_d  = 1'b0;
                    step2_d  = 1'b0;
                end
            end
            ST_STEP_LOW: begin
                if (abort || abort_pend_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (tmr_tc) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == STEP_CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        enter_high = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (enter_high) begin
            state_d  = ST_STEP_HIGH;
            tmr_load = 1'b1;
            tmr_val  = HIGH_LOAD;
            err_d    = minor_step ? (err_sum - {1'b0, major_q}) : err_sum;
            step1_d  = maj1_q | minor_step;
            step2_d  = !maj1_q | minor_step;
`ifdef STEPPER_POS_TRACK_EN
            if (maj1_q | minor_step) begin
                pos1_d = dir1_q ? pos1_q + 64'sd1 : pos1_q - 64'sd1;
            end
            if (!maj1_q | minor_step) begin
                pos2_d = dir2_q ? pos2_q + 64'sd1 : pos2_q - 64'sd1;
            end
`endif
        end

        ready_d = (state_d == ST_IDLE) && !zero_acc;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            major_q      <= '0;
            minor_q      <= '0;
            rem_q        <= '0;
            err_q        <= '0;
            maj1_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            step1_q      <= 1'b0;
            step2_q      <= 1'b0;
            dir1_q       <= 1'b0;
            dir2_q       <= 1'b0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
`ifdef STEPPER_POS_TRACK_EN
            pos1_q       <= '0;
            pos2_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            major_q      <= major_d;
            minor_q      <= minor_d;
            rem_q        <= rem_d;
            err_q        <= err_d;
            maj1_q       <= maj1_d;
            abort_pend_q <= abort_pend_d;
            step1_q      <= step1_d;
            step2_q      <= step2_d;
            dir1_q       <= dir1_d;
            dir2_q       <= dir2_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
`ifdef STEPPER_POS_TRACK_EN
            pos1_q       <= pos1_d;
            pos2_q       <= pos2_d;
`endif
        end
    end

    assign step1         = step1_q;
    assign step2         = step2_q;
    assign dir1_out      = dir1_q;
    assign dir2_out      = dir2_q;
    assign stepper_ready = ready_q;
    assign move_done     = done_q;
`ifdef STEPPER_POS_TRACK_EN
    assign pos1          = pos1_q;
    assign pos2          = pos2_q;
`endif

endmodule
